milano_pipe_ctrl: RTL and testbench



---
 rtl/milano_pipe_ctrl_if.sv | 19 +
 rtl/milano_pipe_ctrl.sv | 137 +++++++++++++
 tb/tb_milano_pipe_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/milano_pipe_ctrl_if.sv
// Data-memory request/grant/rvalid handshake between the milano pipeline
// controller (master) and the data memory (slave).
interface milano_pipe_ctrl_if;
  logic data_req;
  logic data_gnt;
  logic data_rvalid;

  modport master (
    output data_req,
    input  data_gnt,
    input  data_rvalid
  );

  modport slave (
    input  data_req,
    output data_gnt,
    output data_rvalid
  );
endinterface

// File: rtl/milano_pipe_ctrl.sv
// Pipeline sequencing controller for the milano core: load-use hazard stall,
// taken-branch flush, LSU memory handshake sequencing and stall-cycle counter.
module milano_pipe_ctrl #(
  parameter int GNT_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 id_valid_i,
  input  logic [4:0]           id_rs1_addr_i,
  input  logic [4:0]           id_rs2_addr_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [4:0]           ex_rd_addr_i,
  input  logic                 ex_rd_wr_en_i,
  input  logic                 ex_lsu_req_i,
  input  logic                 ex_lsu_we_i,
  input  logic                 branch_taken_i,
  milano_pipe_ctrl_if.master   mem,
  output logic                 stall_if_o,
  output logic                 stall_id_o,
  output logic                 ex_hold_o,
  output logic                 flush_id_o,
  output logic                 flush_ex_o,
  output logic                 lsu_err_o,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  localparam int TO_W = (GNT_TIMEOUT > 2) ? $clog2(GNT_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(GNT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              lsu_err_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic              req;
  logic              lsu_done;
  logic              timeout;
  logic              hold;
  logic              load_use;
  logic              stall;
  logic              rs1_match;
  logic              rs2_match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      lsu_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      lsu_err_q   <= timeout;
      if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  // Handshake sequencing; a granted store finishes in the grant cycle,
  // a granted load waits for rvalid.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    req      = 1'b0;
    lsu_done = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        req = ex_lsu_req_i;
        if (ex_lsu_req_i) begin
          if (mem.data_gnt) begin
            if (ex_lsu_we_i) lsu_done = 1'b1;
            else             state_d  = WAIT_RVALID;
          end else begin
            state_d  = WAIT_GNT;
            to_cnt_d = '0;
          end
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (mem.data_gnt) begin
          if (ex_lsu_we_i) begin
            lsu_done = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = WAIT_RVALID;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout  = 1'b1;
          lsu_done = 1'b1;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WAIT_RVALID: begin
        if (mem.data_rvalid) begin
          lsu_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rs1_match = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_match = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);

  assign load_use = ex_lsu_req_i && !ex_lsu_we_i && ex_rd_wr_en_i &&
                    (ex_rd_addr_i != 5'd0) && id_valid_i && (rs1_match || rs2_match);

  // Priority: EX hold, then branch flush, then load-use bubble.
  assign hold  = ex_lsu_req_i && !lsu_done;
  assign stall = rst_ni && (hold || (!branch_taken_i && load_use));

  assign mem.data_req = rst_ni && req;
  assign ex_hold_o    = rst_ni && hold;
  assign stall_if_o   = stall;
  assign stall_id_o   = stall;
  assign flush_id_o   = rst_ni && !hold && branch_taken_i;
  assign flush_ex_o   = rst_ni && !hold && (branch_taken_i || load_use);
  assign lsu_err_o    = lsu_err_q;
  assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_milano_pipe_ctrl.sv
// Scoreboard bench for milano_pipe_ctrl: per-cycle expected outputs are queued
// with the stimulus and compared in the middle of the cycle.
module tb_milano_pipe_ctrl;

  typedef struct packed {
    logic        req;
    logic        stall;
    logic        hold;
    logic        fid;
    logic        fex;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, rs1_used, rs2_used, rd_we, lsu_req, lsu_we, br;
  logic [4:0] rs1, rs2, rd;
  logic stall_if, stall_id, ex_hold, flush_id, flush_ex, lsu_err;
  logic [15:0] stall_cnt;

  logic sat_lsu_req;
  logic zero1;
  logic [4:0] zero5;
  logic s_stall_if, s_stall_id, s_hold, s_fid, s_fex, s_err;
  logic [3:0] s_cnt;

  int n_chk = 0;
  int n_err = 0;
  exp_t sb[$];

  milano_pipe_ctrl_if mem_if ();
  milano_pipe_ctrl_if sat_if ();

  always #5 clk = ~clk;

  milano_pipe_ctrl #(.GNT_TIMEOUT(16), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid), .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
    .ex_rd_addr_i(rd), .ex_rd_wr_en_i(rd_we), .ex_lsu_req_i(lsu_req),
    .ex_lsu_we_i(lsu_we), .branch_taken_i(br), .mem(mem_if),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .ex_hold_o(ex_hold),
    .flush_id_o(flush_id), .flush_ex_o(flush_ex), .lsu_err_o(lsu_err),
    .stall_cnt_o(stall_cnt)
  );

  milano_pipe_ctrl #(.GNT_TIMEOUT(16), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(zero1), .id_rs1_addr_i(zero5), .id_rs2_addr_i(zero5),
    .id_rs1_used_i(zero1), .id_rs2_used_i(zero1),
    .ex_rd_addr_i(zero5), .ex_rd_wr_en_i(zero1), .ex_lsu_req_i(sat_lsu_req),
    .ex_lsu_we_i(zero1), .branch_taken_i(zero1), .mem(sat_if),
    .stall_if_o(s_stall_if), .stall_id_o(s_stall_id), .ex_hold_o(s_hold),
    .flush_id_o(s_fid), .flush_ex_o(s_fex), .lsu_err_o(s_err),
    .stall_cnt_o(s_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic req, input logic stall, input logic hold,
                              input logic fid, input logic fex, input logic err,
                              input int cnt);
    exp_t e;
    e.req = req; e.stall = stall; e.hold = hold;
    e.fid = fid; e.fex = fex; e.err = err; e.cnt = 16'(cnt);
    return e;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                        input logic u1, input logic u2);
    id_valid = v; rs1 = a1; rs2 = a2; rs1_used = u1; rs2_used = u2;
  endtask

  task automatic drv(input logic lreq, input logic lwe, input logic [4:0] d,
                     input logic gnt, input logic rvalid, input logic b);
    lsu_req = lreq; lsu_we = lwe; rd = d; rd_we = 1'b1;
    mem_if.data_gnt = gnt; mem_if.data_rvalid = rvalid; br = b;
  endtask

  // Queue the expectation for the cycle just driven, compare mid-cycle,
  // then return just after the next rising edge.
  task automatic step(input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(negedge clk);
    x = sb.pop_front();
    check_val("data_req", mem_if.data_req, x.req);
    check_val("stall_if", stall_if, x.stall);
    check_val("stall_id", stall_id, x.stall);
    check_val("ex_hold", ex_hold, x.hold);
    check_val("flush_id", flush_id, x.fid);
    check_val("flush_ex", flush_ex, x.fex);
    check_val("lsu_err", lsu_err, x.err);
    check_val("stall_cnt", stall_cnt, x.cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cnt);
    set_id(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    step(mk(0, 0, 0, 0, 0, 0, cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    zero1 = 1'b0; zero5 = '0; sat_lsu_req = 1'b0;
    sat_if.data_gnt = 1'b0; sat_if.data_rvalid = 1'b0;
    rst_n = 1'b0;
    // Reset with a live hazard and request on the inputs: everything reads 0
    set_id(1, 5, 5, 1, 1);
    drv(1, 0, 5, 1, 0, 1);
    #12;
    check_val("rst_req", mem_if.data_req, 0);
    check_val("rst_stall", stall_if, 0);
    check_val("rst_hold", ex_hold, 0);
    check_val("rst_flush", flush_ex | flush_id, 0);
    check_val("rst_err", lsu_err, 0);
    check_val("rst_cnt", stall_cnt, 0);
    check_val("rst_sat_cnt", s_cnt, 0);
    @(posedge clk); #1;
    set_id(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Zero-wait load to x5, ID reads x5 via rs2
    set_id(1, 0, 5, 0, 1);
    drv(1, 0, 5, 1, 0, 0); step(mk(1, 1, 1, 0, 0, 0, 0));
    drv(1, 0, 5, 0, 1, 0); step(mk(0, 1, 0, 0, 1, 0, 1));
    idle(2);

    // Store with grant 3 cycles late; ID reads the store's rd
    set_id(1, 4, 0, 1, 0);
    drv(1, 1, 4, 0, 0, 0); step(mk(1, 1, 1, 0, 0, 0, 2));
    step(mk(1, 1, 1, 0, 0, 0, 3));
    step(mk(1, 1, 1, 0, 0, 0, 4));
    drv(1, 1, 4, 1, 0, 0); step(mk(1, 0, 0, 0, 0, 0, 5));
    // stray gnt/rvalid with no request
    set_id(0, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 1, 0); step(mk(0, 0, 0, 0, 0, 0, 5));

    // Load never granted: 16 cycles in WAIT_GNT then timeout
    drv(1, 0, 9, 0, 0, 0); step(mk(1, 1, 1, 0, 0, 0, 5));
    for (int k = 0; k < 15; k++) step(mk(1, 1, 1, 0, 0, 0, 6 + k));
    step(mk(1, 0, 0, 0, 0, 0, 21));
    drv(0, 0, 0, 0, 0, 0); step(mk(0, 0, 0, 0, 0, 1, 21));
    drv(1, 0, 9, 1, 0, 0); step(mk(1, 1, 1, 0, 0, 0, 21));
    drv(1, 0, 9, 0, 1, 0); step(mk(0, 0, 0, 0, 0, 0, 22));
    idle(22);

    // Taken branch during hold, then with a load-use match on x3
    set_id(1, 3, 0, 1, 0);
    drv(1, 0, 3, 1, 0, 1); step(mk(1, 1, 1, 0, 0, 0, 22));
    drv(1, 0, 3, 0, 1, 1); step(mk(0, 0, 0, 1, 1, 0, 23));
    idle(23);

    // x0 destination and unused rs1 never hazard; used rs1 does
    set_id(1, 0, 0, 1, 1);
    drv(1, 0, 0, 1, 0, 0); step(mk(1, 1, 1, 0, 0, 0, 23));
    drv(1, 0, 0, 0, 1, 0); step(mk(0, 0, 0, 0, 0, 0, 24));
    set_id(1, 7, 2, 0, 1);
    drv(1, 0, 7, 1, 0, 0); step(mk(1, 1, 1, 0, 0, 0, 24));
    drv(1, 0, 7, 0, 1, 0); step(mk(0, 0, 0, 0, 0, 0, 25));
    set_id(1, 7, 2, 1, 0);
    drv(1, 0, 7, 1, 0, 0); step(mk(1, 1, 1, 0, 0, 0, 25));
    drv(1, 0, 7, 0, 1, 0); step(mk(0, 1, 0, 0, 1, 0, 26));
    idle(27);

    // Reset asserted while in WAIT_RVALID
    set_id(1, 6, 0, 1, 0);
    drv(1, 0, 6, 1, 0, 0); step(mk(1, 1, 1, 0, 0, 0, 27));
    drv(1, 0, 6, 0, 0, 0); step(mk(0, 1, 1, 0, 0, 0, 28));
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_hold", ex_hold, 0);
    check_val("mid_rst_stall", stall_if, 0);
    check_val("mid_rst_cnt", stall_cnt, 0);
    step(mk(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    set_id(0, 0, 0, 0, 0);
    drv(0, 0, 6, 0, 1, 0); step(mk(0, 0, 0, 0, 0, 0, 0));
    drv(1, 0, 6, 0, 0, 0); step(mk(1, 1, 1, 0, 0, 0, 0));
    drv(1, 0, 6, 1, 0, 0); step(mk(1, 1, 1, 0, 0, 0, 1));
    drv(1, 0, 6, 0, 1, 0); step(mk(0, 0, 0, 0, 0, 0, 2));
    idle(2);

    // 4-bit counter held in a permanent stall saturates at 15
    sat_lsu_req = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_val("sat_cnt_20", s_cnt, 15);
    repeat (5) @(posedge clk);
    #1;
    check_val("sat_cnt_25", s_cnt, 15);
    sat_lsu_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
